// File: rtl/i2c_seq_if.sv
// Control handshake and register-bus strobes between the init sequencer and the
// shared I2C register bus. The tristate data byte stays a plain inout port on i2c_seq.
interface i2c_seq_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] address;
    logic       rd;
    logic       wr;

    modport master (input start, output busy, done, err, address, rd, wr);
    modport slave  (output start, input busy, done, err, address, rd, wr);
endinterface

// File: rtl/i2c_seq.sv
// ROM-driven I2C init sequencer: replays write transactions into the I2C master FIFO.
// Optional macro I2C_SEQ_DELAY_EN adds the 0x00,D delay-entry format and DELAY state.
module i2c_seq #(
    parameter int unsigned I2C_BASEADDR = 0,
    parameter string       TABLE_FILE   = "i2c_seq.hex",
    parameter int unsigned TABLE_LEN    = 64,
    parameter int unsigned POLL_DIV     = 256,
    parameter int unsigned POLL_TIMEOUT = 4096,
    parameter int unsigned DELAY_UNIT   = 1000
) (
    input  logic       clk,
    input  logic       nreset,
    i2c_seq_if.master  bus,
    inout  wire [7:0]  data
);
    localparam int unsigned PW = $clog2(TABLE_LEN);
    localparam int unsigned DW = $clog2(POLL_DIV + 1);
    localparam int unsigned TW = $clog2(POLL_TIMEOUT + 1);
    // one extra pointer bit so the pointer can sit at TABLE_LEN
    localparam logic [PW:0]   LEN_P     = (PW+1)'(TABLE_LEN);
    localparam logic [DW-1:0] DIV_LAST  = DW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(POLL_TIMEOUT - 1);
    localparam logic [7:0]    ADDR_ST   = 8'(I2C_BASEADDR);
    localparam logic [7:0]    ADDR_FIFO = 8'(I2C_BASEADDR + 1);

    if (TABLE_LEN < 2 || POLL_DIV < 1 || POLL_TIMEOUT < 1 || DELAY_UNIT < 1) begin : g_bad_param
        $error("i2c_seq: parameter out of range");
    end

    typedef enum logic [3:0] {
        IDLE, FETCH, HDR, PUSH, GAP, POLL_WAIT, POLL_RD, POLL_CHK, END
`ifdef I2C_SEQ_DELAY_EN
        , DELAY
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          fault;
    logic [7:0]    rom [TABLE_LEN];
    logic [7:0]    rom_q;
    logic [PW:0]   ptr_q;
    logic [7:0]    rem_q;
    logic [DW-1:0] div_q;
    logic [TW-1:0] poll_q;
    logic          rd_ph_q;
    logic          stat_q;
    logic          busy_q, done_q, err_q;
    logic [7:0]    addr_q;
    logic          rd_o, wr_o;
    logic          unused_hi;

`ifdef I2C_SEQ_DELAY_EN
    localparam int unsigned UW = $clog2(DELAY_UNIT + 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(DELAY_UNIT - 1);
    logic          dly_pend_q;
    logic [UW-1:0] tick_q;
    logic [7:0]    nt_q;
    logic          dly_done;
    assign dly_done = (tick_q == UNIT_LAST) && (nt_q == rom_q - 8'd1);
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // rem_q == 0 at FETCH means the next byte is a header, so table end is a clean stop there
    always_comb begin
        state_d = state_q;
        fault   = 1'b0;
        unique case (state_q)
            IDLE:      if (bus.start) state_d = FETCH;
            FETCH: begin
                if (ptr_q == LEN_P) begin
                    if (rem_q == '0) state_d = END;
                    else begin
                        fault   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (rem_q != '0) state_d = PUSH;
`ifdef I2C_SEQ_DELAY_EN
                else if (dly_pend_q) state_d = DELAY;
`endif
                else state_d = HDR;
            end
            HDR: begin
                if (rom_q[7]) state_d = PUSH;
                else if (rom_q == '0) begin
`ifdef I2C_SEQ_DELAY_EN
                    state_d = FETCH;
`else
                    state_d = END;
`endif
                end else begin
                    fault   = 1'b1;
                    state_d = IDLE;
                end
            end
            PUSH:      state_d = GAP;
            GAP:       state_d = (rem_q != '0) ? FETCH : POLL_WAIT;
            POLL_WAIT: if (div_q == DIV_LAST) state_d = POLL_RD;
            POLL_RD:   if (rd_ph_q) state_d = POLL_CHK;
            POLL_CHK: begin
                if (!stat_q) state_d = FETCH;
                else if (poll_q == TO_LAST) begin
                    fault   = 1'b1;
                    state_d = IDLE;
                end else state_d = POLL_WAIT;
            end
            END:       state_d = IDLE;
`ifdef I2C_SEQ_DELAY_EN
            DELAY: begin
                if (rom_q == '0) state_d = END;
                else if (dly_done) state_d = FETCH;
            end
`endif
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_o = (state_q == PUSH);
        rd_o = (state_q == POLL_RD);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q   <= '0;
            rem_q   <= '0;
            rom_q   <= '0;
            div_q   <= '0;
            poll_q  <= '0;
            rd_ph_q <= 1'b0;
            stat_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
`ifdef I2C_SEQ_DELAY_EN
            dly_pend_q <= 1'b0;
            tick_q     <= '0;
            nt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    ptr_q  <= '0;
                    rem_q  <= '0;
                    poll_q <= '0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
`ifdef I2C_SEQ_DELAY_EN
                    dly_pend_q <= 1'b0;
`endif
                end
                FETCH: begin
                    if (ptr_q != LEN_P) rom_q <= rom[ptr_q[PW-1:0]];
`ifdef I2C_SEQ_DELAY_EN
                    dly_pend_q <= 1'b0;
`endif
                end
                HDR: begin
                    poll_q <= '0;
                    if (rom_q[7]) rem_q <= {1'b0, rom_q[6:0]} + 8'd2;
`ifdef I2C_SEQ_DELAY_EN
                    else if (rom_q == '0) begin
                        ptr_q      <= ptr_q + 1'b1;
                        dly_pend_q <= 1'b1;
                    end
`endif
                end
                PUSH: begin
                    ptr_q <= ptr_q + 1'b1;
                    rem_q <= rem_q - 8'd1;
                end
                POLL_WAIT: div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                POLL_RD: begin
                    rd_ph_q <= ~rd_ph_q;
                    if (rd_ph_q) stat_q <= data[0];
                end
                POLL_CHK: if (stat_q) poll_q <= poll_q + 1'b1;
                END: done_q <= 1'b1;
`ifdef I2C_SEQ_DELAY_EN
                DELAY: if (rom_q != '0) begin
                    if (tick_q == UNIT_LAST) begin
                        tick_q <= '0;
                        if (dly_done) begin
                            nt_q  <= '0;
                            ptr_q <= ptr_q + 1'b1;
                        end else nt_q <= nt_q + 8'd1;
                    end else tick_q <= tick_q + 1'b1;
                end
`endif
                default: ;
            endcase
            busy_q <= (state_d != IDLE);
            if (fault) err_q <= 1'b1;
            // address is registered ahead of the strobe so it holds through GAP
            if (state_d == PUSH)         addr_q <= ADDR_FIFO;
            else if (state_d == POLL_RD) addr_q <= ADDR_ST;
        end
    end

    assign unused_hi   = ^data[7:1];
    assign data        = wr_o ? rom_q : 'z;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.address = addr_q;
    assign bus.rd      = rd_o;
    assign bus.wr      = wr_o;
endmodule
